// File: rtl/riscv_pkg.sv
// Shared RV32I load/store definitions: funct3 codes, access sizes and the LSU state encoding.
package riscv_pkg;

    localparam logic [2:0] Funct3Lb  = 3'b000;
    localparam logic [2:0] Funct3Lh  = 3'b001;
    localparam logic [2:0] Funct3Lw  = 3'b010;
    localparam logic [2:0] Funct3Lbu = 3'b100;
    localparam logic [2:0] Funct3Lhu = 3'b101;
    localparam logic [2:0] Funct3Sb  = 3'b000;
    localparam logic [2:0] Funct3Sh  = 3'b001;
    localparam logic [2:0] Funct3Sw  = 3'b010;

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} lsu_state_e;

    typedef enum logic [1:0] {SizeByte, SizeHalf, SizeWord} lsu_size_e;

    // Reserved codes (011, 110, 111) fall through to a word access.
    function automatic lsu_size_e lsu_size(input logic [2:0] funct3);
        unique case (funct3)
            Funct3Lb, Funct3Lbu: return SizeByte;
            Funct3Lh, Funct3Lhu: return SizeHalf;
            default:             return SizeWord;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Memory request/response channel between the LSU (master) and the memory (slave).
interface lsu_if #(
    parameter int unsigned ADDR_W = 32
) ();

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_rsp_valid;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_req_ready, mem_rsp_valid, mem_rdata
    );

    modport slave (
        input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_req_ready, mem_rsp_valid, mem_rdata
    );

endinterface

// File: rtl/lsu_extend.sv
// Load lane select and sign/zero extension of a 32-bit memory word.
module lsu_extend
    import riscv_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    output logic [31:0] value
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rdata[8*offset +: 8];
        lane_h = offset[1] ? rdata[31:16] : rdata[15:0];
        value  = rdata;
        // funct3[2] marks the unsigned variants LBU/LHU.
        unique case (lsu_size(funct3))
            SizeByte: value = funct3[2] ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
            SizeHalf: value = funct3[2] ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default:  value = rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit: one memory operation per start, IDLE/REQ/WAIT/DONE FSM.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses on a fault port instead of aligning them.
module lsu
    import riscv_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              is_load,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_val,
    output logic              busy,
    output logic              done,
    output logic [31:0]       load_result,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic              fault,
`endif
    lsu_if.master             mem
);

    lsu_state_e        state_q;
    logic              busy_q, done_q, req_valid_q, we_q, is_load_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       wdata_q, load_result_q;
    logic [3:0]        wstrb_q;
    logic [2:0]        funct3_q;
    logic [1:0]        offset_q;

    lsu_size_e   size;
    logic [1:0]  offset;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] ext_value;
    logic        trap;

    // offset is the byte offset with the bits below the access width cleared.
    always_comb begin
        size = lsu_size(funct3);
        unique case (size)
            SizeByte: begin
                offset = addr[1:0];
                strb   = 4'b0001 << offset;
                wdata  = {4{store_val[7:0]}};
            end
            SizeHalf: begin
                offset = {addr[1], 1'b0};
                strb   = 4'b0011 << offset;
                wdata  = {2{store_val[15:0]}};
            end
            default: begin
                offset = 2'b00;
                strb   = 4'b1111;
                wdata  = store_val;
            end
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic fault_q;
    assign trap  = (offset != addr[1:0]);
    assign fault = fault_q;
`else
    assign trap = 1'b0;
`endif

    lsu_extend u_extend (
        .rdata  (mem.mem_rdata),
        .funct3 (funct3_q),
        .offset (offset_q),
        .value  (ext_value)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            req_valid_q   <= 1'b0;
            we_q          <= 1'b0;
            wstrb_q       <= '0;
            mem_addr_q    <= '0;
            wdata_q       <= '0;
            load_result_q <= '0;
            is_load_q     <= 1'b0;
            funct3_q      <= '0;
            offset_q      <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            fault_q       <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        busy_q    <= 1'b1;
                        is_load_q <= is_load;
                        funct3_q  <= funct3;
                        offset_q  <= offset;
                        if ((is_load || is_store) && !trap) begin
                            state_q     <= StReq;
                            req_valid_q <= 1'b1;
                            we_q        <= !is_load;
                            mem_addr_q  <= {addr[ADDR_W-1:2], 2'b00};
                            wstrb_q     <= is_load ? 4'b0000 : strb;
                            wdata_q     <= wdata;
                        end else begin
                            // No-op and trapped accesses complete without bus traffic.
                            state_q <= StDone;
                            done_q  <= 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
                            fault_q <= (is_load || is_store) && trap;
`endif
                        end
                    end
                end
                StReq: begin
                    if (mem.mem_req_ready) begin
                        req_valid_q <= 1'b0;
                        we_q        <= 1'b0;
                        wstrb_q     <= 4'b0000;
                        if (is_load_q) begin
                            state_q <= StWait;
                        end else begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end
                    end
                end
                StWait: begin
                    if (mem.mem_rsp_valid) begin
                        load_result_q <= ext_value;
                        state_q       <= StDone;
                        done_q        <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
                    fault_q <= 1'b0;
`endif
                end
            endcase
        end
    end

    assign busy              = busy_q;
    assign done              = done_q;
    assign load_result       = load_result_q;
    assign mem.mem_req_valid = req_valid_q;
    assign mem.mem_we        = we_q;
    assign mem.mem_addr      = mem_addr_q;
    assign mem.mem_wdata     = wdata_q;
    assign mem.mem_wstrb     = wstrb_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios plus randomized loads/stores against a byte-level model.
module tb_lsu;

    localparam int unsigned ADDR_W = 32;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        is_load = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] store_val = '0;
    logic        busy, done;
    logic [31:0] load_result;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        fault;
`endif

    lsu_if #(.ADDR_W(ADDR_W)) mem_bus ();

    lsu #(.ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .is_load     (is_load),
        .is_store    (is_store),
        .funct3      (funct3),
        .addr        (addr),
        .store_val   (store_val),
        .busy        (busy),
        .done        (done),
        .load_result (load_result),
`ifdef LSU_MISALIGN_TRAP_EN
        .fault       (fault),
`endif
        .mem         (mem_bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_lr = '0;

    typedef struct {
        int          done_cnt;
        int          done_cyc;
        int          req_cnt;
        int          ready_cyc;
        logic        we;
        logic [31:0] maddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        bit          stable;
        logic        busy_mid;
        logic        busy_after;
        logic [31:0] lr_after;
        logic        fault_done;
    } obs_t;

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic int eff_off(input logic [31:0] a, input int nb);
        int raw = int'(a[1:0]);
        return (raw / nb) * nb;
    endfunction

    function automatic bit misaligned(input logic [31:0] a, input int nb);
        return (int'(a[1:0]) % nb) != 0;
    endfunction

    function automatic logic [3:0] model_strb(input logic [31:0] a, input int nb);
        logic [3:0] s = '0;
        int off = eff_off(a, nb);
        for (int i = 0; i < 4; i++) s[i] = (i >= off) && (i < off + nb);
        return s;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] v, input int nb);
        logic [31:0] w = '0;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = v[8*(i % nb) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [31:0] a,
                                               input logic [2:0] f3);
        logic [31:0] v = '0;
        int nb  = nbytes(f3);
        int off = eff_off(a, nb);
        bit sgn = (f3 == 3'b000) || (f3 == 3'b001);
        for (int i = 0; i < nb; i++) v[8*i +: 8] = rd[8*(off + i) +: 8];
        if (sgn && v[8*nb-1]) begin
            for (int i = 8 * nb; i < 32; i++) v[i] = 1'b1;
        end
        return v;
    endfunction

    // ---------------- bus driver / observer ----------------
    task automatic run_op(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] val, input logic [31:0] rd, input int ready_wait,
                          input int rsp_wait, input bit noise, input bit poke, output obs_t o);
        int cyc = 0;
        int hs_cyc = -1;
        int seen_cyc = -1;
        bit rsp_sent = 1'b0;
        o = '{default: 0};
        o.done_cyc = -1;
        o.ready_cyc = -1;
        o.stable = 1'b1;
        @(negedge clk);
        start = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; store_val = val;
        while (cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) o.busy_mid = busy;
            if (done) begin
                o.done_cnt++;
                o.done_cyc = cyc;
`ifdef LSU_MISALIGN_TRAP_EN
                o.fault_done = fault;
`endif
            end
            if (o.done_cyc >= 0 && cyc == o.done_cyc + 1) begin
                o.busy_after = busy;
                o.lr_after = load_result;
            end
            mem_bus.mem_req_ready = 1'b0;
            if (mem_bus.mem_req_valid) begin
                if (seen_cyc < 0) begin
                    seen_cyc = cyc;
                    o.we = mem_bus.mem_we; o.maddr = mem_bus.mem_addr;
                    o.wdata = mem_bus.mem_wdata; o.wstrb = mem_bus.mem_wstrb;
                end else if (hs_cyc < 0 && (o.we !== mem_bus.mem_we || o.maddr !== mem_bus.mem_addr
                             || o.wdata !== mem_bus.mem_wdata || o.wstrb !== mem_bus.mem_wstrb)) begin
                    o.stable = 1'b0;
                end
                if (cyc - seen_cyc >= ready_wait) begin
                    mem_bus.mem_req_ready = 1'b1;
                    o.req_cnt++;
                    if (hs_cyc < 0) begin
                        hs_cyc = cyc;
                        o.ready_cyc = cyc;
                    end
                end
            end else if (seen_cyc >= 0 && hs_cyc < 0) begin
                o.stable = 1'b0;
            end
            mem_bus.mem_rsp_valid = 1'b0;
            if (ld && hs_cyc >= 0 && !rsp_sent && cyc == hs_cyc + 1 + rsp_wait) begin
                mem_bus.mem_rsp_valid = 1'b1;
                mem_bus.mem_rdata = rd;
                rsp_sent = 1'b1;
            end else if (noise && (hs_cyc < 0 || rsp_sent || !ld)) begin
                mem_bus.mem_rsp_valid = 1'($urandom % 2);
                mem_bus.mem_rdata = $urandom;
            end
            start = poke && (o.done_cnt == 0);
            is_load = 1'($urandom % 2); is_store = 1'($urandom % 2);
            funct3 = 3'($urandom % 8); addr = $urandom; store_val = $urandom;
            if (o.done_cyc >= 0 && cyc >= o.done_cyc + 2) break;
        end
        start = 1'b0;
        mem_bus.mem_req_ready = 1'b0;
        mem_bus.mem_rsp_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (mem_bus.mem_req_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got=%b want=0", mem_bus.mem_req_valid); end
        checks++; if (mem_bus.mem_we !== 1'b0) begin
            errors++; $display("FAIL reset_we got=%b want=0", mem_bus.mem_we); end
        checks++; if (mem_bus.mem_wstrb !== 4'b0000) begin
            errors++; $display("FAIL reset_wstrb got=%b want=0000", mem_bus.mem_wstrb); end
        checks++; if (load_result !== 32'h0) begin
            errors++; $display("FAIL reset_load_result got=%h want=0", load_result); end
`ifdef LSU_MISALIGN_TRAP_EN
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b want=0", fault); end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_load_lb();
        obs_t o;
        run_op(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 0, 0, 1'b0, 1'b0, o);
        exp_lr = 32'hFFFF_FF80;
        checks++; if (o.done_cyc !== 3) begin errors++; $display("FAIL lb_latency got=%0d want=3", o.done_cyc); end
        checks++; if (o.lr_after !== exp_lr) begin
            errors++; $display("FAIL lb_result got=%h want=%h", o.lr_after, exp_lr); end
        checks++; if (o.maddr !== 32'h100 || o.we !== 1'b0 || o.wstrb !== 4'b0000) begin
            errors++; $display("FAIL lb_request got=%h/%b/%b want=00000100/0/0000", o.maddr, o.we, o.wstrb); end
    endtask

    task automatic test_store_sh();
        obs_t o;
        run_op(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000_BEEF, 32'h0, 0, 0, 1'b0, 1'b0, o);
        checks++; if (o.maddr !== 32'h200) begin errors++; $display("FAIL sh_addr got=%h want=00000200", o.maddr); end
        checks++; if (o.wstrb !== 4'b1100) begin errors++; $display("FAIL sh_wstrb got=%b want=1100", o.wstrb); end
        checks++; if (o.wdata !== 32'hBEEF_BEEF) begin
            errors++; $display("FAIL sh_wdata got=%h want=beefbeef", o.wdata); end
        checks++; if (o.we !== 1'b1) begin errors++; $display("FAIL sh_we got=%b want=1", o.we); end
        checks++; if (o.done_cyc !== 2) begin errors++; $display("FAIL sh_latency got=%0d want=2", o.done_cyc); end
        checks++; if (o.lr_after !== exp_lr) begin
            errors++; $display("FAIL sh_keeps_result got=%h want=%h", o.lr_after, exp_lr); end
    endtask

    task automatic test_backpressure();
        obs_t o;
        run_op(1'b0, 1'b1, 3'b010, 32'h300, 32'h1234_5678, 32'h0, 5, 0, 1'b0, 1'b0, o);
        checks++; if (o.stable !== 1'b1) begin errors++; $display("FAIL bp_stable got=%b want=1", o.stable); end
        checks++; if (o.ready_cyc !== 6) begin errors++; $display("FAIL bp_ready_cycle got=%0d want=6", o.ready_cyc); end
        checks++; if (o.done_cyc !== 7) begin errors++; $display("FAIL bp_done_cycle got=%0d want=7", o.done_cyc); end
        checks++; if (o.req_cnt !== 1) begin errors++; $display("FAIL bp_requests got=%0d want=1", o.req_cnt); end
    endtask

    task automatic test_busy_start();
        obs_t o;
        run_op(1'b1, 1'b0, 3'b010, 32'h404, 32'h0, 32'hCAFE_F00D, 0, 3, 1'b0, 1'b1, o);
        exp_lr = 32'hCAFE_F00D;
        checks++; if (o.done_cnt !== 1) begin errors++; $display("FAIL busy_start_done_pulses got=%0d want=1", o.done_cnt); end
        checks++; if (o.req_cnt !== 1) begin errors++; $display("FAIL busy_start_requests got=%0d want=1", o.req_cnt); end
        checks++; if (o.done_cyc !== 6) begin errors++; $display("FAIL busy_start_latency got=%0d want=6", o.done_cyc); end
        checks++; if (o.lr_after !== exp_lr) begin
            errors++; $display("FAIL busy_start_result got=%h want=%h", o.lr_after, exp_lr); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h40;
        @(negedge clk);
        start = 1'b0;
        mem_bus.mem_req_ready = 1'b1;
        @(negedge clk);
        mem_bus.mem_req_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (mem_bus.mem_req_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL midreset_async got=%b/%b want=0/0", mem_bus.mem_req_valid, busy); end
        checks++; if (load_result !== 32'h0) begin
            errors++; $display("FAIL midreset_result got=%h want=0", load_result); end
        exp_lr = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1; is_load = 1'b0; is_store = 1'b1; funct3 = 3'b010; addr = 32'h50;
        store_val = 32'h1111_2222;
        mem_bus.mem_rsp_valid = 1'b1; mem_bus.mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0;
        mem_bus.mem_rsp_valid = 1'b0;
        checks++; if (mem_bus.mem_req_valid !== 1'b1 || mem_bus.mem_we !== 1'b1) begin
            errors++; $display("FAIL first_cycle_accept got=%b/%b want=1/1", mem_bus.mem_req_valid, mem_bus.mem_we); end
        checks++; if (load_result !== 32'h0) begin
            errors++; $display("FAIL late_rsp_ignored got=%h want=0", load_result); end
        mem_bus.mem_req_ready = 1'b1;
        @(negedge clk);
        mem_bus.mem_req_ready = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL post_reset_store_done got=%b want=1", done); end
        @(negedge clk);
    endtask

`ifdef LSU_MISALIGN_TRAP_EN
    task automatic test_misalign_trap();
        obs_t o;
        run_op(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h5555_AAAA, 0, 0, 1'b0, 1'b0, o);
        checks++; if (o.req_cnt !== 0) begin errors++; $display("FAIL trap_no_request got=%0d want=0", o.req_cnt); end
        checks++; if (o.done_cyc !== 1 || o.fault_done !== 1'b1) begin
            errors++; $display("FAIL trap_fault_done got=%0d/%b want=1/1", o.done_cyc, o.fault_done); end
    endtask
`endif

    task automatic test_random();
        obs_t o;
        for (int n = 0; n < 40; n++) begin
            int          kind = int'($urandom % 5);
            bit          ld = (kind < 2);
            bit          st = (kind == 2 || kind == 3) || (ld && ($urandom % 2 == 1));
            logic [2:0]  f3 = 3'($urandom % 8);
            logic [31:0] a = $urandom;
            logic [31:0] v = $urandom;
            logic [31:0] rd = $urandom;
            int          rw = int'($urandom % 4);
            int          pw = int'($urandom % 4);
            int          nb = nbytes(f3);
            bit          trapped = TRAP && (ld || st) && misaligned(a, nb);
            bit          bus = (ld || st) && !trapped;
            int          exp_done = !bus ? 1 : (ld ? 3 + rw + pw : 2 + rw);
            run_op(ld, st, f3, a, v, rd, rw, pw, 1'b1, 1'b0, o);
            if (bus && ld) exp_lr = model_load(rd, a, f3);
            checks++; if (o.done_cnt !== 1) begin
                errors++; $display("FAIL rnd%0d_done_pulses got=%0d want=1", n, o.done_cnt); end
            checks++; if (o.done_cyc !== exp_done) begin
                errors++; $display("FAIL rnd%0d_latency got=%0d want=%0d", n, o.done_cyc, exp_done); end
            checks++; if (o.req_cnt !== (bus ? 1 : 0)) begin
                errors++; $display("FAIL rnd%0d_requests got=%0d want=%0d", n, o.req_cnt, bus ? 1 : 0); end
            checks++; if (o.lr_after !== exp_lr) begin
                errors++; $display("FAIL rnd%0d_load_result got=%h want=%h", n, o.lr_after, exp_lr); end
            checks++; if (o.busy_mid !== 1'b1 || o.busy_after !== 1'b0) begin
                errors++; $display("FAIL rnd%0d_busy got=%b/%b want=1/0", n, o.busy_mid, o.busy_after); end
            if (bus) begin
                checks++; if (o.maddr !== a - (a % 4) || o.we !== !ld || o.stable !== 1'b1) begin
                    errors++; $display("FAIL rnd%0d_request got=%h/%b/%b want=%h/%b/1",
                                       n, o.maddr, o.we, o.stable, a - (a % 4), !ld); end
                checks++; if (o.wstrb !== (ld ? 4'b0000 : model_strb(a, nb))) begin
                    errors++; $display("FAIL rnd%0d_wstrb got=%b want=%b", n, o.wstrb,
                                       ld ? 4'b0000 : model_strb(a, nb)); end
                if (!ld) begin
                    checks++; if (o.wdata !== model_wdata(v, nb)) begin
                        errors++; $display("FAIL rnd%0d_wdata got=%h want=%h", n, o.wdata, model_wdata(v, nb)); end
                end
            end
            if (trapped) begin
                checks++; if (o.fault_done !== 1'b1) begin
                    errors++; $display("FAIL rnd%0d_fault got=%b want=1", n, o.fault_done); end
            end
        end
    endtask

    initial begin
        mem_bus.mem_req_ready = 1'b0;
        mem_bus.mem_rsp_valid = 1'b0;
        mem_bus.mem_rdata = '0;
        test_reset();
        test_load_lb();
        test_store_sh();
        test_backpressure();
        test_busy_start();
        test_reset_mid();
`ifdef LSU_MISALIGN_TRAP_EN
        test_misalign_trap();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the byte address width of addr and mem_addr.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 start  input  1  SHALL request one memory operation, sampled only in IDLE.
REQ-005 is_load / is_store  input  1 each  SHALL select the operation; is_load SHALL win if both are set.
REQ-006 funct3  input  3  SHALL be the RV32I width/sign code.
REQ-007 addr  input  ADDR_W  SHALL be the effective byte address (rs1 + imm).
REQ-008 store_val  input  32  SHALL be the store source (rs2 value).
REQ-009 busy  output  1  SHALL be high in every state except IDLE.
REQ-010 done  output  1  SHALL be a one-cycle completion pulse.
REQ-011 load_result  output  32  SHALL be the extended load value consumed at register writeback.
REQ-012 fault  output  1  SHALL flag a misaligned access; it SHALL exist only with LSU_MISALIGN_TRAP_EN.
REQ-013 mem_req_valid out 1, mem_req_ready in 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out 32, mem_wstrb out 4 SHALL form the request channel.
REQ-014 mem_rsp_valid in 1, mem_rdata in 32 SHALL form the load response channel.

Function
REQ-015 The FSM SHALL have states IDLE, REQ, WAIT, DONE.
REQ-016 IDLE→REQ on start with is_load|is_store. IDLE→DONE on start with neither set, with no bus traffic.
REQ-017 In REQ, mem_req_valid SHALL be 1, and addr, we, wdata and wstrb SHALL stay stable until mem_req_valid && mem_req_ready.
REQ-018 On the REQ handshake, a store SHALL go to DONE and a load SHALL go to WAIT.
REQ-019 In WAIT, mem_rsp_valid SHALL capture the extended mem_rdata into load_result and move the FSM to DONE.
REQ-020 mem_rsp_valid outside WAIT SHALL be ignored.
REQ-021 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-022 start while busy SHALL be ignored.
REQ-023 Minimum latency, with start at cycle 0 and ready at cycle 1:
- store: done at cycle 2.
- load, with rsp at cycle 2: done at cycle 3.
REQ-024 mem_addr SHALL be {addr[ADDR_W-1:2], 2'b00}.
REQ-025 Stores SHALL drive mem_we=1 and the following strobes:
- SB (000): wstrb = 0001<<addr[1:0], wdata = the byte replicated 4×.
- SH (001): wstrb = 0011<<(2·addr[1]), wdata = the half replicated 2×.
- SW (010): wstrb = 1111.
REQ-026 Loads SHALL drive mem_we=0 and wstrb=0000.
REQ-027 Load extension SHALL select the lane by addr[1:0]:
- LB (000) / LH (001): sign-extend.
- LBU (100) / LHU (101): zero-extend.
- LW (010): pass through.
REQ-028 Reserved funct3 values (011, 110, 111) SHALL be handled as word accesses.
REQ-029 load_result SHALL hold its value until the next load completes; stores SHALL not alter it.
REQ-030 The FSM SHALL latch addr, funct3, store_val and the operation at start acceptance; later input changes SHALL have no effect.

Reset
REQ-031 Asserting rst_n low SHALL immediately force the following, including mid-transaction:
- state = IDLE.
- mem_req_valid = busy = done = fault = 0.
- load_result = 0, mem_wstrb = 0, mem_we = 0.
REQ-032 After reset release, the first cycle SHALL be IDLE and SHALL accept start.

Configuration
REQ-033 With LSU_MISALIGN_TRAP_EN defined, a misaligned access SHALL skip the bus and go IDLE→DONE with fault=1 during DONE. Misaligned means a half with addr[0]=1 or a word with addr[1:0]≠0.
REQ-034 Without LSU_MISALIGN_TRAP_EN, the fault port SHALL be absent and misaligned addresses SHALL be forced aligned (offset bits cleared for the access width).

Structure
REQ-035 A shared package riscv_pkg SHALL hold the funct3 load/store constants and the lsu state enum.
REQ-036 The byte-lane select and sign/zero extension SHALL be a sub-module lsu_extend, used for load_result.

Verification
REQ-037 LB at addr=0x103 with rdata=0x80FF_1234 SHALL give load_result=0xFFFF_FF80 and done 3 cycles after start.
REQ-038 SH at addr=0x202 with store_val=0x0000_BEEF SHALL give mem_addr=0x200, wstrb=1100, wdata=0xBEEF_BEEF, we=1.
REQ-039 mem_req_ready held low for 5 cycles SHALL keep valid, addr and wstrb stable, with done 1 cycle after ready rises.
REQ-040 rst_n pulsed low in WAIT SHALL immediately set mem_req_valid=0 and busy=0; a late mem_rsp_valid in IDLE SHALL leave load_result=0.
REQ-041 With LSU_MISALIGN_TRAP_EN, LW at addr=0x101 SHALL produce no mem_req_valid, fault=1 and done=1 in the same cycle.
REQ-042 A second start during WAIT SHALL be ignored: exactly one done pulse and one bus request.
